// File: rtl/instr_sequencer_if.sv
// Memory-side bus of the instruction sequencer: combinational program-memory
// read port plus a req/ack data-memory port.
interface instr_sequencer_if;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;

    // dmem handshake: the sequencer holds dmem_req (and dmem_we) steady until
    // the cycle in which dmem_ack=1; that cycle completes the transfer.
    // dmem_ack is only meaningful while dmem_req=1.
    modport master (output imem_addr, input imem_rdata,
                    output dmem_req, output dmem_we, input dmem_ack);
    modport slave  (input imem_addr, output imem_rdata,
                    input dmem_req, input dmem_we, output dmem_ack);
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for an 8-bit instruction set.
// Optional feature macro: SEQ_TIMEOUT_EN (data-memory ack timeout, sticky err).
module instr_sequencer (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    instr_sequencer_if.master      mem,
    output logic [7:0]             ir,
    output logic [7:0]             imm_data,
    output logic                   alu_en,
    output logic                   rf_we,
    output logic                   instr_done,
    output logic [2:0]             state,
    output logic                   err
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        IMM    = 3'd3,
        EXEC   = 3'd4,
        MEM    = 3'd5,
        WB     = 3'd6
    } state_t;

    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_CM  = 4'b0111;
    localparam logic [3:0] OP_CMI = 4'b1111;

    state_t     state_q, state_d;
    logic [7:0] pc;
    logic [3:0] opcode;
    logic       is_imm;
    logic       pc_inc, ir_load, imm_load;
    logic       req, we;
    logic       timeout_hit;

    assign opcode        = ir[7:4];
    assign state         = state_q;
    assign mem.imem_addr = pc;
    assign mem.dmem_req  = req;
    assign mem.dmem_we   = we;

    always_comb begin
        is_imm = 1'b0;
        case (opcode)
            4'b0010, 4'b1001, 4'b1011, 4'b1100,
            4'b1101, 4'b1110, 4'b1111: is_imm = 1'b1;
            default:                   is_imm = 1'b0;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    logic [3:0] to_cnt;
    logic       err_q;

    // to_cnt counts ack-less MEM cycles; the 16th one abandons the access.
    assign timeout_hit = (state_q == MEM) && !mem.dmem_ack && (to_cnt == 4'hF);
    assign err         = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= 4'h0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == MEM && !mem.dmem_ack) to_cnt <= to_cnt + 4'h1;
            else                                 to_cnt <= 4'h0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        alu_en     = 1'b0;
        rf_we      = 1'b0;
        instr_done = 1'b0;
        req        = 1'b0;
        we         = 1'b0;
        pc_inc     = 1'b0;
        ir_load    = 1'b0;
        imm_load   = 1'b0;
        case (state_q)
            IDLE: if (run && !err) state_d = FETCH;
            FETCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                if (is_imm)                   state_d = IMM;
                else if (opcode[3:1] == 3'b0) state_d = MEM;
                else                          state_d = EXEC;
            end
            IMM: begin
                imm_load = 1'b1;
                pc_inc   = 1'b1;
                state_d  = EXEC;
            end
            EXEC: begin
                alu_en  = 1'b1;
                state_d = WB;
            end
            MEM: begin
                req = 1'b1;
                we  = (opcode == OP_ST);
                if (mem.dmem_ack) begin
                    if (opcode == OP_ST) begin
                        instr_done = 1'b1;
                        state_d    = run ? FETCH : IDLE;
                    end else begin
                        state_d = WB;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WB: begin
                // Compares only update flags, never a register.
                rf_we      = (opcode != OP_CM) && (opcode != OP_CMI);
                instr_done = 1'b1;
                state_d    = run ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc       <= 8'h00;
            ir       <= 8'h00;
            imm_data <= 8'h00;
        end else begin
            state_q <= state_d;
            if (pc_inc)   pc       <= pc + 8'h01;
            if (ir_load)  ir       <= mem.imem_rdata;
            if (imm_load) imm_data <= mem.imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table of single instructions plus
// hand sequences for back-to-back, pc wrap, reset in MEM and ack timeout.
module tb_instr_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] ir, imm_data;
  logic       alu_en, rf_we, instr_done, err;
  logic [2:0] state;
  logic [7:0] imem [256];

  int n_cmp = 0;
  int n_err = 0;

  instr_sequencer_if bus ();

  assign bus.imem_rdata = imem[bus.imem_addr];

  instr_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mem        (bus.master),
    .ir         (ir),
    .imm_data   (imm_data),
    .alu_en     (alu_en),
    .rf_we      (rf_we),
    .instr_done (instr_done),
    .state      (state),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [7:0] imm;
    int         w;
    int         lat;
    int         alu_c;
    int         rf_c;
    int         req_n;
    int         we_n;
    logic [7:0] pc;
    logic [7:0] imm_exp;
    bit         noisy;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic [7:0] op, logic [7:0] imm, int w, int lat,
                              int alu_c, int rf_c, int req_n, int we_n,
                              logic [7:0] pc, logic [7:0] imm_exp, bit noisy);
    vec_t v;
    v.op = op; v.imm = imm; v.w = w; v.lat = lat; v.alu_c = alu_c;
    v.rf_c = rf_c; v.req_n = req_n; v.we_n = we_n; v.pc = pc;
    v.imm_exp = imm_exp; v.noisy = noisy;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int done_c, alu_c, rf_c, alu_n, rf_n, done_n, req_n, we_n, viol;
    done_c = 0; alu_c = 0; rf_c = 0; alu_n = 0; rf_n = 0; done_n = 0;
    req_n = 0; we_n = 0; viol = 0;
    do_reset();
    imem[0] = v.op;
    imem[1] = v.imm;
    @(negedge clk);
    run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.dmem_ack = (v.w > 0 && k == 2 + v.w) || (v.noisy && k <= 2);
      #1;
      if (k == 1) run = 1'b0;
      if (alu_en) begin alu_n++; if (alu_c == 0) alu_c = k; end
      if (rf_we) begin rf_n++; if (rf_c == 0) rf_c = k; end
      if (bus.dmem_req) req_n++;
      if (bus.dmem_req && bus.dmem_we) we_n++;
      if (int'(alu_en) + int'(rf_we) + int'(bus.dmem_req) > 1) viol++;
      if (instr_done) begin done_n++; if (done_c == 0) done_c = k; end
      if (done_c != 0 && k == done_c + 1) begin
        chk($sformatf("v%0d parked", idx), state, 0);
        break;
      end
    end
    bus.dmem_ack = 1'b0;
    chk($sformatf("v%0d retire_cycle", idx), done_c, v.lat);
    chk($sformatf("v%0d done_pulses", idx), done_n, 1);
    chk($sformatf("v%0d alu_cycle", idx), alu_c, v.alu_c);
    chk($sformatf("v%0d alu_pulses", idx), alu_n, (v.alu_c != 0) ? 1 : 0);
    chk($sformatf("v%0d rf_cycle", idx), rf_c, v.rf_c);
    chk($sformatf("v%0d rf_pulses", idx), rf_n, (v.rf_c != 0) ? 1 : 0);
    chk($sformatf("v%0d req_cycles", idx), req_n, v.req_n);
    chk($sformatf("v%0d we_cycles", idx), we_n, v.we_n);
    chk($sformatf("v%0d exclusive", idx), viol, 0);
    chk($sformatf("v%0d ir", idx), ir, v.op);
    chk($sformatf("v%0d imm", idx), imm_data, v.imm_exp);
    chk($sformatf("v%0d pc", idx), bus.imem_addr, v.pc);
  endtask

  initial begin
    int dones, req_n, d1, d2;
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;

    // Reset state, checked before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk("rst state", state, 0);
    chk("rst pc", bus.imem_addr, 0);
    chk("rst ir", ir, 0);
    chk("rst imm", imm_data, 0);
    chk("rst req", bus.dmem_req, 0);
    chk("rst we", bus.dmem_we, 0);
    chk("rst alu", alu_en, 0);
    chk("rst rf", rf_we, 0);
    chk("rst done", instr_done, 0);
    chk("rst err", err, 0);

    //            op     imm    w  lat alu rf req we pc     imm    noisy
    vecs[0]  = mk(8'h46, 8'hFF, 0, 4, 3, 4, 0, 0, 8'h01, 8'h00, 1);
    vecs[1]  = mk(8'hE5, 8'h3C, 0, 5, 4, 5, 0, 0, 8'h02, 8'h3C, 0);
    vecs[2]  = mk(8'h10, 8'hFF, 3, 5, 0, 0, 3, 3, 8'h01, 8'h00, 1);
    vecs[3]  = mk(8'h7A, 8'hFF, 0, 4, 3, 0, 0, 0, 8'h01, 8'h00, 0);
    vecs[4]  = mk(8'h0B, 8'hFF, 1, 4, 0, 4, 1, 0, 8'h01, 8'h00, 0);
    vecs[5]  = mk(8'hF3, 8'h55, 0, 5, 4, 0, 0, 0, 8'h02, 8'h55, 1);
    vecs[6]  = mk(8'h20, 8'hAA, 0, 5, 4, 5, 0, 0, 8'h02, 8'hAA, 0);
    vecs[7]  = mk(8'h30, 8'hFF, 0, 4, 3, 4, 0, 0, 8'h01, 8'h00, 1);
    vecs[8]  = mk(8'h05, 8'hFF, 4, 7, 0, 7, 4, 0, 8'h01, 8'h00, 0);
    vecs[9]  = mk(8'h91, 8'h01, 0, 5, 4, 5, 0, 0, 8'h02, 8'h01, 0);
    vecs[10] = mk(8'h80, 8'hFF, 0, 4, 3, 4, 0, 0, 8'h01, 8'h00, 0);
    vecs[11] = mk(8'hA0, 8'hFF, 0, 4, 3, 4, 0, 0, 8'h01, 8'h00, 0);
    vecs[12] = mk(8'h1C, 8'hFF, 1, 3, 0, 0, 1, 1, 8'h01, 8'h00, 1);
    vecs[13] = mk(8'hB2, 8'h7E, 0, 5, 4, 5, 0, 0, 8'h02, 8'h7E, 0);
    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Back-to-back with run held high: retires at cycles 4 and 8.
    do_reset();
    imem[0] = 8'h46; imem[1] = 8'h30;
    @(negedge clk);
    run = 1'b1;
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      if (instr_done) begin if (d1 == 0) d1 = k; else d2 = k; end
    end
    run = 1'b0;
    chk("b2b first_retire", d1, 4);
    chk("b2b second_retire", d2, 8);
    chk("b2b ir", ir, 8'h30);
    @(negedge clk); #1;
    chk("b2b parked", state, 0);
    chk("b2b pc", bus.imem_addr, 2);

    // pc wrap: opcode at 0xFF, immediate at 0x00.
    do_reset();
    for (int i = 0; i < 255; i++) imem[i] = 8'h46;
    imem[255] = 8'hC0;
    @(negedge clk);
    run = 1'b1;
    dones = 0;
    for (int k = 1; k <= 2000 && dones < 256; k++) begin
      @(negedge clk); #1;
      if (instr_done) dones++;
    end
    run = 1'b0;
    chk("wrap retire_count", dones, 256);
    chk("wrap ir", ir, 8'hC0);
    chk("wrap imm", imm_data, 8'h46);
    chk("wrap pc", bus.imem_addr, 8'h01);
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;

    // Reset asserted while an LD waits in MEM.
    do_reset();
    imem[0] = 8'h05;
    @(negedge clk);
    run = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rmem req_before", bus.dmem_req, 1);
    reset = 1'b0;
    #1;
    chk("rmem req_async", bus.dmem_req, 0);
    chk("rmem state_async", state, 0);
    chk("rmem pc_async", bus.imem_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rmem refetch_state", state, 1);
    chk("rmem refetch_pc", bus.imem_addr, 0);
    run = 1'b0;

    // Ack never arrives.
    do_reset();
    imem[0] = 8'h05;
    @(negedge clk);
    run = 1'b1;
    req_n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); #1;
      if (bus.dmem_req) req_n++;
    end
`ifdef SEQ_TIMEOUT_EN
    chk("tmo req_cycles", req_n, 16);
    chk("tmo err", err, 1);
    chk("tmo idle", state, 0);
    chk("tmo done", instr_done, 0);
`else
    chk("wait req_cycles", req_n, 38);
    chk("wait err", err, 0);
    chk("wait in_mem", state, 5);
`endif
    run = 1'b0;
    do_reset();
    @(negedge clk); #1;
    chk("err cleared", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
